temp_rd_arbiter: RTL
====================

TEMP_RD_ARBITER -- requirements
Module: temp_rd_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter RAM_LAT, default 1: cycles from ramAddr update to ramData valid; legal range 1..3.
REQ-003 Parameter STARVE_MAX, default 8: consecutive port-0 grants allowed while port 1 waits; legal range 1..15.
REQ-004 clk  in  1  system clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 req0  in  1  frame-builder read request, level, held until ack0.
REQ-007 addr0  in  7  frame-builder temperature RAM address.
REQ-008 req1  in  1  service-port read request, level, held until ack1.
REQ-009 addr1  in  7  service-port temperature RAM address.
REQ-010 ramData  in  8  temperature RAM read data.
REQ-011 ramAddr  out  7  registered temperature RAM read address.
REQ-012 ack0 / ack1  out  1  one-cycle pulse; data0 / data1 valid in that cycle.
REQ-013 data0 / data1  out  8  captured read data, held until that port's next ack.
REQ-014 busy  out  1  high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT, ACK.
REQ-016 In IDLE with any request high, the FSM SHALL grant, register the granted address into ramAddr, load wait counter = RAM_LAT, and go to WAIT.
REQ-017 Default priority SHALL be port 0 over port 1.
REQ-018 The address SHALL be latched at grant; later addrN changes SHALL NOT affect the transaction.
REQ-019 WAIT SHALL decrement the counter; at the edge where it is 0, ramData SHALL be captured into the granted dataN, ackN set, and the FSM SHALL go to ACK.
REQ-020 Latency: request sampled at edge T -> ackN high during the cycle after edge T+RAM_LAT+1.
REQ-021 ACK SHALL last exactly one cycle, then IDLE; requests SHALL NOT be sampled in ACK.
REQ-022 Back-to-back throughput SHALL be one read per RAM_LAT+3 cycles.
REQ-023 A request dropped before its ack SHALL NOT abort the transaction; the ack still pulses.
REQ-024 ack0 and ack1 SHALL never be high in the same cycle.
REQ-025 The non-granted port's dataN SHALL hold its value.
REQ-026 ramAddr SHALL hold its last value in IDLE.

Reset
REQ-027 rst SHALL force IDLE, ramAddr=0, data0=data1=0, ack0=ack1=0, busy=0, starvation counter=0.
REQ-028 Reset mid-transaction SHALL discard the read; no ack SHALL be issued for it after reset.

Configuration
REQ-029 Macro TEMP_ARB_STARVE_EN SHALL compile in the starvation guard.
REQ-030 With it: a 4-bit counter increments on each port-0 grant made while req1 is high, clears on a port-1 grant or a grant with req1 low, and saturates at STARVE_MAX; when it equals STARVE_MAX and both requests are high, port 1 SHALL be granted.
REQ-031 Without it: strict port-0 priority, no counter logic.

Verification
REQ-032 Single read: RAM_LAT=1; req0=1, addr0=0x2A, RAM word 0x2A=0x5C -> ramAddr=0x2A; ack0 pulses 2 cycles after sample with data0=0x5C; ack1 stays 0.
REQ-033 Contention: req0 and req1 rise together, addr0=0x01, addr1=0x40 -> port 0 is served first; port 1 is served next with ramAddr=0x40, starting RAM_LAT+3 cycles after the first sample.
REQ-034 Starvation (macro on, STARVE_MAX=8): req0 and req1 held high -> 8 port-0 acks, then 1 port-1 ack, then port 0 resumes. Macro off: port 1 is never granted while req0 stays high.
REQ-035 Address change: addr1 changes from 0x10 to 0x11 one cycle after grant -> ramAddr stays 0x10; data1 = RAM[0x10].
REQ-036 Reset in WAIT (RAM_LAT=3): rst pulsed one cycle after grant -> no ack0; all outputs 0; busy=0 the cycle after reset.

Source files
------------

// File: rtl/temp_rd_arbiter.sv
// -----------------------------------------------------------------------------
// temp_rd_arbiter
//   Arbitrates two read requesters (frame builder on port 0, service port on
//   port 1) onto a single temperature RAM read port with fixed read latency.
//   One read is in flight at a time: IDLE -> WAIT (RAM_LAT+1 edges) -> ACK.
//
// Parameters
//   RAM_LAT    : cycles from ramAddr update to ramData valid (1..3)
//   STARVE_MAX : consecutive port-0 grants tolerated while port 1 waits (1..15)
//
// Optional feature
//   TEMP_ARB_STARVE_EN : when defined, compiles in the port-1 starvation guard.
//                        When undefined, port 0 has strict priority.
//
// Ports
//   clk     in   1  system clock, rising edge
//   rst     in   1  synchronous reset, active-high
//   req0    in   1  port-0 read request (level, held until ack0)
//   addr0   in   7  port-0 RAM address
//   req1    in   1  port-1 read request (level, held until ack1)
//   addr1   in   7  port-1 RAM address
//   ramData in   8  RAM read data
//   ramAddr out  7  registered RAM read address
//   ack0    out  1  one-cycle pulse, data0 valid
//   ack1    out  1  one-cycle pulse, data1 valid
//   data0   out  8  captured read data for port 0
//   data1   out  8  captured read data for port 1
//   busy    out  1  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module temp_rd_arbiter #(
  parameter int unsigned RAM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [6:0] addr0,
  input  logic       req1,
  input  logic [6:0] addr1,
  input  logic [7:0] ramData,
  output logic [6:0] ramAddr,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] data0,
  output logic [7:0] data1,
  output logic       busy
);

  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned STARVE_W = 4;

  // Reject out-of-range configurations at elaboration.
  if (RAM_LAT < 1 || RAM_LAT > 3 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_param_check
    $error("temp_rd_arbiter: RAM_LAT must be 1..3 and STARVE_MAX 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                r_gnt1;
  logic                w_gnt1_nxt;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [ADDR_W-1:0]   w_ram_addr_nxt;
  logic [DATA_W-1:0]   r_data0;
  logic [DATA_W-1:0]   w_data0_nxt;
  logic [DATA_W-1:0]   r_data1;
  logic [DATA_W-1:0]   w_data1_nxt;
  logic                r_ack0;
  logic                w_ack0_nxt;
  logic                r_ack1;
  logic                w_ack1_nxt;
  logic                r_busy;
  logic                w_busy_nxt;

  logic                w_any_req;
  logic                w_pick1;

  assign w_any_req = req0 | req1;

`ifdef TEMP_ARB_STARVE_EN
  // Starvation guard: count port-0 grants that bypassed a waiting port 1.
  logic [STARVE_W-1:0] r_starve;
  logic [STARVE_W-1:0] w_starve_nxt;
  logic                w_starve_hit;

  assign w_starve_hit = (r_starve == STARVE_W'(STARVE_MAX));
  assign w_pick1      = req1 & (~req0 | w_starve_hit);

  // Counter update happens only on a grant decision in IDLE.
  always_comb begin
    w_starve_nxt = r_starve;
    if (r_state == S_IDLE && w_any_req) begin
      if (!w_pick1 && req1) begin
        if (!w_starve_hit) begin
          w_starve_nxt = r_starve + STARVE_W'(1);
        end
      end else begin
        w_starve_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else begin
      r_starve <= w_starve_nxt;
    end
  end
`else
  // Strict priority: port 1 only when port 0 is idle.
  assign w_pick1 = req1 & ~req0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_gnt1_nxt     = r_gnt1;
    w_ram_addr_nxt = r_ram_addr;
    w_data0_nxt    = r_data0;
    w_data1_nxt    = r_data1;
    w_ack0_nxt     = 1'b0;
    w_ack1_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          // Address is frozen here; later addrN changes are ignored.
          w_gnt1_nxt     = w_pick1;
          w_ram_addr_nxt = w_pick1 ? addr1 : addr0;
          w_cnt_nxt      = CNT_W'(RAM_LAT);
          w_state_nxt    = S_WAIT;
        end
      end

      S_WAIT: begin
        if (r_cnt == '0) begin
          // ramData has been valid for the required latency; capture it.
          if (r_gnt1) begin
            w_data1_nxt = ramData;
            w_ack1_nxt  = 1'b1;
          end else begin
            w_data0_nxt = ramData;
            w_ack0_nxt  = 1'b1;
          end
          w_state_nxt = S_ACK;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      S_ACK: begin
        // Requests are deliberately not sampled here.
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_gnt1     <= 1'b0;
      r_ram_addr <= '0;
      r_data0    <= '0;
      r_data1    <= '0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_gnt1     <= w_gnt1_nxt;
      r_ram_addr <= w_ram_addr_nxt;
      r_data0    <= w_data0_nxt;
      r_data1    <= w_data1_nxt;
      r_ack0     <= w_ack0_nxt;
      r_ack1     <= w_ack1_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign ramAddr = r_ram_addr;
  assign ack0    = r_ack0;
  assign ack1    = r_ack1;
  assign data0   = r_data0;
  assign data1   = r_data1;
  assign busy    = r_busy;

endmodule
